// File: rtl/if2id_skid_reg.sv
// ---------------------------------------------------------------------------
// if2id_skid_reg
// Fetch-to-decode pipeline register with a valid/ready handshake and a
// 2-entry skid buffer. in_ready comes straight from a flop, so a freeze
// from decode never reaches fetch combinationally. While no valid entry is
// held, the outputs carry a bubble: NOP_INSTR and a zero PC. Those values
// are written into the data registers, not masked at the outputs.
//
// Optional feature (macro IF2ID_STALL_CNT_EN):
//   defined   - stall_cnt counts cycles with main_v & freeze & ~flush and
//               saturates at all-ones. Only rst clears it.
//   undefined - no counter logic is built and stall_cnt is tied to 0.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   freeze         in   decode stalled; the output entry is not consumed
//   flush          in   synchronous kill of held and incoming entries
//   in_valid       in   fetch presents an entry
//   in_ready       out  entry can be accepted this cycle (registered)
//   pc             in   fetch PC
//   instruction_in in   fetched instruction
//   out_valid      out  instruction/pc_out hold a real entry
//   instruction    out  decode-side instruction
//   pc_out         out  decode-side PC
//   stall_cnt      out  stall-cycle count (optional feature)
//
// state | meaning
// EMPTY | main_v=0, skid_v=0 : outputs show a bubble
// ONE   | main_v=1, skid_v=0 : main entry on the outputs
// FULL  | main_v=1, skid_v=1 : main on the outputs, next entry parked in skid
// ---------------------------------------------------------------------------
module if2id_skid_reg #(
    parameter int                   INSTR_W   = 32,
    parameter int                   PC_W      = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'hE0000000,
    parameter int                   CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_W-1:0]     pc,
    input  logic [INSTR_W-1:0]  instruction_in,
    output logic                out_valid,
    output logic [INSTR_W-1:0]  instruction,
    output logic [PC_W-1:0]     pc_out,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic                r_main_v;
    logic                r_skid_v;
    logic [INSTR_W-1:0]  r_main_instr;
    logic [PC_W-1:0]     r_main_pc;
    logic [INSTR_W-1:0]  r_skid_instr;
    logic [PC_W-1:0]     r_skid_pc;

    logic                w_acc;
    logic                w_con;
    logic [1:0]          w_state;

    assign w_acc   = in_valid & ~r_skid_v;
    assign w_con   = r_main_v & ~freeze;
    assign w_state = {r_main_v, r_skid_v};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v     <= 1'b0;
            r_skid_v     <= 1'b0;
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
        end else if (flush) begin
            // Flush wins over freeze and drops any same-cycle incoming entry.
            r_main_v     <= 1'b0;
            r_skid_v     <= 1'b0;
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
        end else begin
            case (w_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main_v     <= 1'b1;
                        r_main_instr <= instruction_in;
                        r_main_pc    <= pc;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_con) begin
                        r_main_instr <= instruction_in;
                        r_main_pc    <= pc;
                    end else if (w_acc) begin
                        r_skid_v     <= 1'b1;
                        r_skid_instr <= instruction_in;
                        r_skid_pc    <= pc;
                    end else if (w_con) begin
                        // Drain: load the bubble so the outputs need no mask.
                        r_main_v     <= 1'b0;
                        r_main_instr <= NOP_INSTR;
                        r_main_pc    <= '0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a consume can happen.
                    if (w_con) begin
                        r_skid_v     <= 1'b0;
                        r_main_instr <= r_skid_instr;
                        r_main_pc    <= r_skid_pc;
                    end
                end
                default: begin
                    // skid without main is unreachable; recover to EMPTY.
                    r_main_v     <= 1'b0;
                    r_skid_v     <= 1'b0;
                    r_main_instr <= NOP_INSTR;
                    r_main_pc    <= '0;
                end
            endcase
        end
    end

    assign in_ready    = ~r_skid_v;
    assign out_valid   = r_main_v;
    assign instruction = r_main_instr;
    assign pc_out      = r_main_pc;

`ifdef IF2ID_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_main_v && freeze && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
